// File: rtl/shared_seg_tx_sched.sv
// Round-robin transmit scheduler for dirty shared-memory segments with gap and timeout handling.
// Optional periodic full refresh is built in when SHARED_TX_REFRESH_EN is defined.
module shared_seg_tx_sched #(
    parameter int SEG_COUNT      = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int REFRESH_PERIOD = 1000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [$clog2(SEG_COUNT):0]   wr_seg,
    output logic                         send_req,
    output logic [$clog2(SEG_COUNT)-1:0] send_seg,
    input  logic                         send_ack,
    input  logic                         send_done,
    output logic                         busy,
    output logic [$clog2(SEG_COUNT):0]   pending,
    output logic                         timeout,
    output logic                         err_seg
);

    localparam int SW = $clog2(SEG_COUNT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [SEG_COUNT-1:0]   dirty_q, dirty_d;
    logic [SW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]          seg_q, seg_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [TW-1:0]          to_q, to_d;
    logic [SW:0]            pending_q, pending_d;
    logic                   timeout_q, timeout_d;
    logic                   err_q, err_d;
    logic                   sel_found;
    logic [SW-1:0]          sel_idx;
    logic                   refresh_hit;

    // REFRESH_PERIOD only feeds logic when the refresh counter is built in.
    if (REFRESH_PERIOD < 1) begin : g_refresh_period_unused
    end

`ifdef SHARED_TX_REFRESH_EN
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    logic [RW-1:0] refresh_q;

    assign refresh_hit = (refresh_q == RW'(REFRESH_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst || refresh_hit) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + RW'(1);
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // First dirty segment at or after rr_ptr, wrapping naturally in SW bits.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < SEG_COUNT; i++) begin
            if (!sel_found && dirty_q[rr_ptr_q + SW'(i)]) begin
                sel_found = 1'b1;
                sel_idx   = rr_ptr_q + SW'(i);
            end
        end
    end

    always_comb begin
        pending_d = '0;
        for (int unsigned i = 0; i < SEG_COUNT; i++) begin
            pending_d = pending_d + (SW+1)'(dirty_q[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        dirty_d   = dirty_q;
        rr_ptr_d  = rr_ptr_q;
        seg_d     = seg_q;
        gap_d     = gap_q;
        to_d      = to_q;
        timeout_d = 1'b0;
        err_d     = wr_valid && wr_seg[SW];

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    seg_d            = sel_idx;
                    dirty_d[sel_idx] = 1'b0;
                    rr_ptr_d         = sel_idx + SW'(1);
                    state_d          = S_REQ;
                end
            end
            S_REQ: begin
                if (send_ack) begin
                    to_d    = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (send_done) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end else if (to_q == TO_LAST) begin
                    dirty_d[seg_q] = 1'b1;
                    timeout_d      = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Sets are applied after the selection clear so a same-cycle write wins.
        if (wr_valid && !wr_seg[SW]) begin
            dirty_d[wr_seg[SW-1:0]] = 1'b1;
        end
        if (refresh_hit) begin
            dirty_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dirty_q   <= '0;
            rr_ptr_q  <= '0;
            seg_q     <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            pending_q <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dirty_q   <= dirty_d;
            rr_ptr_q  <= rr_ptr_d;
            seg_q     <= seg_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign send_req = (state_q == S_REQ);
    assign busy     = (state_q != S_IDLE);
    assign send_seg = seg_q;
    assign pending  = pending_q;
    assign timeout  = timeout_q;
    assign err_seg  = err_q;

endmodule

// File: tb/tb_shared_seg_tx_sched.sv
// Directed bench for shared_seg_tx_sched: latency, round-robin order, set/clear race,
// timeout, bad segment index, reset mid-transfer and refresh (SHARED_TX_REFRESH_EN).
module tb_shared_seg_tx_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_seg = '0;
    logic       send_ack = 1'b0;
    logic       send_done = 1'b0;
    logic       send_req;
    logic [2:0] send_seg;
    logic       busy;
    logic [3:0] pending;
    logic       timeout;
    logic       err_seg;

    int n_checks = 0;
    int n_fail   = 0;

    shared_seg_tx_sched #(
        .SEG_COUNT     (8),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(4096),
        .REFRESH_PERIOD(100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_seg   (wr_seg),
        .send_req (send_req),
        .send_seg (send_seg),
        .send_ack (send_ack),
        .send_done(send_done),
        .busy     (busy),
        .pending  (pending),
        .timeout  (timeout),
        .err_seg  (err_seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_seg(input logic [3:0] seg);
        wr_valid = 1'b1;
        wr_seg   = seg;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (send_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, send_req, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic ack_and_done();
        send_ack = 1'b1;
        tick();
        send_ack  = 1'b0;
        send_done = 1'b1;
        tick();
        send_done = 1'b0;
    endtask

    task automatic serve(input logic [2:0] seg, input logic [3:0] pend_after);
        wait_req("serve_req");
        check("serve_seg", send_seg, seg);
        tick();
        check("serve_pending", pending, pend_after);
        ack_and_done();
    endtask

    initial begin
        tick();
        tick();
        check("rst_send_req", send_req, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_seg", err_seg, 0);
        check("rst_send_seg", send_seg, 0);
        rst = 1'b0;

`ifdef SHARED_TX_REFRESH_EN
        repeat (90) tick();
        check("refresh_quiet_before_period", busy, 0);
        for (int i = 0; i < 8; i++) begin
            serve(3'(i), 4'(7 - i));
        end
        wait_idle("refresh_idle");
`else
        // Write to seg 3; request visible two edges later, then ack/done timing.
        write_seg(4'd3);
        check("lat_no_req_yet", send_req, 0);
        tick();
        check("lat_req", send_req, 1);
        check("lat_seg", send_seg, 3);
        check("lat_busy", busy, 1);
        check("lat_pending_before", pending, 1);
        tick();
        check("lat_pending_after", pending, 0);
        tick();
        check("lat_req_stable", send_req, 1);
        check("lat_seg_stable", send_seg, 3);
        send_ack = 1'b1;
        tick();
        send_ack = 1'b0;
        check("wait_done_req_low", send_req, 0);
        check("wait_done_busy", busy, 1);
        repeat (5) tick();
        send_done = 1'b1;
        tick();
        send_done = 1'b0;
        check("gap_busy_0", busy, 1);
        repeat (3) tick();
        check("gap_busy_3", busy, 1);
        tick();
        check("gap_end_idle", busy, 0);

        // Round-robin order from rr_ptr = 0: prime with seg 7 so writes land while busy.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_seg(4'd7);
        tick();
        check("rr_prime_seg", send_seg, 7);
        write_seg(4'd5);
        write_seg(4'd1);
        write_seg(4'd6);
        tick();
        check("rr_pending_3", pending, 3);
        ack_and_done();
        serve(3'd1, 4'd2);
        serve(3'd5, 4'd1);
        serve(3'd6, 4'd0);
        wait_idle("rr_idle");

        // Same-edge write and selection of seg 2: set wins, sent twice.
        wr_valid = 1'b1;
        wr_seg   = 4'd2;
        tick();
        tick();
        wr_valid = 1'b0;
        check("race_req", send_req, 1);
        check("race_seg", send_seg, 2);
        tick();
        check("race_pending_1", pending, 1);
        ack_and_done();
        serve(3'd2, 4'd0);
        wait_idle("race_idle");

        // Timeout after 4096 cycles in WAIT_DONE, then same segment re-requested.
        write_seg(4'd4);
        tick();
        check("to_req", send_req, 1);
        check("to_seg", send_seg, 4);
        send_ack = 1'b1;
        tick();
        send_ack = 1'b0;
        repeat (4095) tick();
        check("to_not_yet", timeout, 0);
        check("to_still_busy", busy, 1);
        tick();
        check("to_pulse", timeout, 1);
        check("to_idle", busy, 0);
        tick();
        check("to_pulse_one_cycle", timeout, 0);
        check("to_rereq", send_req, 1);
        check("to_reseg", send_seg, 4);
        check("to_pending", pending, 1);
        ack_and_done();
        wait_idle("to_done_idle");

        // Out-of-range segment index.
        write_seg(4'd9);
        check("err_pulse", err_seg, 1);
        check("err_pending", pending, 0);
        check("err_no_busy", busy, 0);
        tick();
        check("err_one_cycle", err_seg, 0);
        check("err_pending_after", pending, 0);
        check("err_still_idle", busy, 0);

        // Reset in WAIT_DONE with dirty bits and simultaneous events.
        write_seg(4'd1);
        tick();
        check("mid_req", send_req, 1);
        send_ack = 1'b1;
        tick();
        send_ack = 1'b0;
        write_seg(4'd6);
        rst       = 1'b1;
        wr_valid  = 1'b1;
        wr_seg    = 4'd6;
        send_done = 1'b1;
        tick();
        check("mid_rst_send_req", send_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_err_seg", err_seg, 0);
        check("mid_rst_send_seg", send_seg, 0);
        rst       = 1'b0;
        wr_valid  = 1'b0;
        send_done = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_pending", pending, 0);

        // Without refresh, no requests appear on an idle scheduler.
        begin
            int seen = 0;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (send_req === 1'b1) seen++;
            end
            check("no_refresh_requests", seen, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
